// File: rtl/store_drain_ctrl.sv
// Drains committed STQ entries oldest-first into the D-cache write port, one per cycle.
// Optional STORE_DRAIN_STALL_CNT_EN adds a saturating stall-cycle counter output.
module store_drain_ctrl #(
  parameter int SIZE_LSQ     = 32,
  parameter int SIZE_LSQ_LOG = 5,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SIZE_LSQ_LOG-1:0] cntStCom_i,
  output logic [SIZE_LSQ_LOG-1:0] stqRdIndex_o,
  input  logic [ADDR_W-1:0]       stqRdAddr_i,
  input  logic [DATA_W-1:0]       stqRdData_i,
  input  logic [1:0]              stqRdSize_i,
  output logic                    dcWrValid_o,
  input  logic                    dcWrReady_i,
  output logic [ADDR_W-1:0]       dcWrAddr_o,
  output logic [DATA_W-1:0]       dcWrData_o,
  output logic [3:0]              dcWrBe_o,
  output logic                    stqRelease_o,
  output logic [SIZE_LSQ_LOG-1:0] stqHeadPtr_o,
  output logic                    drainIdle_o,
`ifdef STORE_DRAIN_STALL_CNT_EN
  output logic [31:0]             drainStallCnt_o,
`endif
  output logic                    drainErr_o
);

  localparam int SUM_W = SIZE_LSQ_LOG + 2;
  localparam logic [SUM_W-1:0] FULL = SUM_W'(SIZE_LSQ);

  logic [SIZE_LSQ_LOG:0] pending;
  logic [SIZE_LSQ_LOG:0] pendingNext;
  logic [SUM_W-1:0]      pendingSum;
  logic                  accept;
  logic                  load;
  logic                  overflow;
  logic                  sizeErr;
  logic [3:0]            beNext;
  logic [DATA_W-1:0]     dataNext;
  logic [ADDR_W-1:0]     addrNext;

  always_comb begin
    accept     = dcWrValid_o & dcWrReady_i;
    load       = (pending != '0) & (~dcWrValid_o | accept);
    pendingSum = SUM_W'(pending) + SUM_W'(cntStCom_i) - SUM_W'(load);
    // The in-flight request still occupies an STQ entry, so it counts toward capacity.
    overflow    = (pendingSum + SUM_W'(dcWrValid_o)) > FULL;
    pendingNext = (pendingSum > FULL) ? FULL[SIZE_LSQ_LOG:0] : pendingSum[SIZE_LSQ_LOG:0];

    beNext  = 4'b0000;
    sizeErr = 1'b0;
    case (stqRdSize_i)
      2'b00:   beNext = 4'b0001 << stqRdAddr_i[1:0];
      2'b01:   beNext = 4'b0011 << {stqRdAddr_i[1], 1'b0};
      2'b10:   beNext = 4'b1111;
      default: sizeErr = load;
    endcase
    dataNext = stqRdData_i << {stqRdAddr_i[1:0], 3'b000};
    addrNext = {stqRdAddr_i[ADDR_W-1:2], 2'b00};
  end

  assign stqRelease_o = accept;
  assign stqRdIndex_o = stqHeadPtr_o + SIZE_LSQ_LOG'(dcWrValid_o);
  assign drainIdle_o  = (pending == '0) & ~dcWrValid_o;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending      <= '0;
      stqHeadPtr_o <= '0;
      dcWrValid_o  <= 1'b0;
      dcWrAddr_o   <= '0;
      dcWrData_o   <= '0;
      dcWrBe_o     <= '0;
      drainErr_o   <= 1'b0;
    end else begin
      pending <= pendingNext;
      if (accept) begin
        stqHeadPtr_o <= stqHeadPtr_o + SIZE_LSQ_LOG'(1);
      end
      // Request fields only change on load, so they stay stable while stalled.
      if (load) begin
        dcWrValid_o <= 1'b1;
        dcWrAddr_o  <= addrNext;
        dcWrData_o  <= dataNext;
        dcWrBe_o    <= beNext;
      end else if (accept) begin
        dcWrValid_o <= 1'b0;
      end
      if (overflow | sizeErr) begin
        drainErr_o <= 1'b1;
      end
    end
  end

`ifdef STORE_DRAIN_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drainStallCnt_o <= '0;
    end else if (dcWrValid_o & ~dcWrReady_i & (drainStallCnt_o != '1)) begin
      drainStallCnt_o <= drainStallCnt_o + 32'd1;
    end
  end
`endif

endmodule
